// File: rtl/raw_frame_parser.sv
`default_nettype none
// ============================================================================
// raw_frame_parser : SD sector sequencer + raw Bayer frame parser to DDR
// Revision: 1.0
// ============================================================================
module raw_frame_parser #(
    parameter int         DATA_W       = 16,
    parameter int         IMG_W        = 1920,
    parameter int         IMG_H        = 1080,
    parameter int         ROW_HEAD_NUM = 8,
    parameter int         ROW_TAIL_NUM = 8,
    parameter int         PIC_HEAD_NUM = 7744,
    parameter int         PIC_TAIL_NUM = 7744,
    parameter int         START_SEC    = 16640,
    parameter logic [1:0] BAYER_INIT   = 2'd1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              loop_en,
    input  logic [1:0]        shift_mode,
    input  logic [25:0]       sd_sec_num,
    input  logic              rd_busy,
    input  logic              sd_rd_val_en,
    input  logic [DATA_W-1:0] sd_rd_val_data,
    output logic              rd_start_en,
    output logic [31:0]       rd_sec_addr,
    output logic              ddr_wr_en,
    output logic [DATA_W-1:0] ddr_wr_data,
    output logic [1:0]        ddr_wr_chan,
    output logic              frame_done,
    output logic [15:0]       frame_cnt,
    output logic              busy
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} seq_t;
    typedef enum logic [2:0] {P_PIC_HEAD, P_ROW_HEAD, P_ROW_DATA, P_ROW_TAIL, P_PIC_TAIL} par_t;

    seq_t        seq_q, seq_d;
    logic        busy_d0, busy_d1, busy_fall;
    logic [25:0] sec_cnt_q, sec_cnt_d;
    logic [31:0] addr_d;
    logic        start_d, restart;

    assign busy_fall = busy_d1 & ~busy_d0;
    assign busy      = (seq_q == S_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_q       <= S_IDLE;
            sec_cnt_q   <= '0;
            rd_sec_addr <= '0;
            rd_start_en <= 1'b0;
            busy_d0     <= 1'b0;
            busy_d1     <= 1'b0;
        end else begin
            seq_q       <= seq_d;
            sec_cnt_q   <= sec_cnt_d;
            rd_sec_addr <= addr_d;
            rd_start_en <= start_d;
            busy_d0     <= rd_busy;
            busy_d1     <= busy_d0;
        end
    end

    always_comb begin
        seq_d     = seq_q;
        sec_cnt_d = sec_cnt_q;
        addr_d    = rd_sec_addr;
        start_d   = 1'b0;
        restart   = 1'b0;
        case (seq_q)
            S_IDLE: begin
                if (enable && (sd_sec_num != '0)) begin
                    restart   = 1'b1;
                    sec_cnt_d = '0;
                    seq_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (busy_fall) begin
                    if (sec_cnt_q == sd_sec_num - 26'd1) begin
                        sec_cnt_d = '0;
                        if (!loop_en)      seq_d   = S_DONE;
                        else if (!enable)  seq_d   = S_IDLE;
                        else               restart = 1'b1;
                    end else if (!enable) begin
                        // playback stopped: the sector in flight has finished
                        sec_cnt_d = '0;
                        seq_d     = S_IDLE;
                    end else begin
                        sec_cnt_d = sec_cnt_q + 26'd1;
                        addr_d    = rd_sec_addr + 32'd1;
                        start_d   = 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (!enable) seq_d = S_IDLE;
            end
            default: seq_d = S_IDLE;
        endcase
        if (restart) begin
            addr_d  = 32'(START_SEC);
            start_d = 1'b1;
        end
    end

    par_t        par_q, par_d;
    logic [31:0] cnt_q, cnt_d, row_q, row_d, seg_len;
    logic        seg_last, pix, fdone;
    logic [2:0]  shamt;

    assign shamt = {shift_mode, 1'b0};

    always_comb begin
        case (par_q)
            P_PIC_HEAD: seg_len = 32'(PIC_HEAD_NUM);
            P_ROW_HEAD: seg_len = 32'(ROW_HEAD_NUM);
            P_ROW_DATA: seg_len = 32'(IMG_W);
            P_ROW_TAIL: seg_len = 32'(ROW_TAIL_NUM);
            default:    seg_len = 32'(PIC_TAIL_NUM);
        endcase
        seg_last = sd_rd_val_en && (cnt_q == seg_len - 32'd1);
        par_d    = par_q;
        cnt_d    = cnt_q;
        row_d    = row_q;
        pix      = 1'b0;
        fdone    = 1'b0;
        if (sd_rd_val_en) begin
            cnt_d = seg_last ? '0 : cnt_q + 32'd1;
            pix   = (par_q == P_ROW_DATA);
            if (seg_last) begin
                case (par_q)
                    P_PIC_HEAD: par_d = P_ROW_HEAD;
                    P_ROW_HEAD: par_d = P_ROW_DATA;
                    P_ROW_DATA: par_d = P_ROW_TAIL;
                    P_ROW_TAIL: begin
                        if (row_q == 32'(IMG_H - 1)) begin
                            row_d = '0;
                            par_d = P_PIC_TAIL;
                        end else begin
                            row_d = row_q + 32'd1;
                            par_d = P_ROW_HEAD;
                        end
                    end
                    default: begin
                        par_d = P_PIC_HEAD;
                        fdone = 1'b1;
                    end
                endcase
            end
        end
        // a clip restart realigns the parser to a fresh frame header
        if (restart) begin
            par_d = P_PIC_HEAD;
            cnt_d = '0;
            row_d = '0;
            pix   = 1'b0;
            fdone = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q       <= P_PIC_HEAD;
            cnt_q       <= '0;
            row_q       <= '0;
            ddr_wr_en   <= 1'b0;
            ddr_wr_data <= '0;
            ddr_wr_chan <= 2'd0;
            frame_done  <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            par_q      <= par_d;
            cnt_q      <= cnt_d;
            row_q      <= row_d;
            ddr_wr_en  <= pix;
            frame_done <= fdone;
            if (fdone) frame_cnt <= frame_cnt + 16'd1;
            if (pix) begin
                ddr_wr_data <= sd_rd_val_data >> shamt;
                ddr_wr_chan <= BAYER_INIT ^ {row_q[0], cnt_q[0]};
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/raw_frame_parser.md
RAW_FRAME_PARSER -- requirements
Module: raw_frame_parser

Interface
REQ-001 SHALL have parameter DATA_W, default 16, SD word and DDR data width.
REQ-002 SHALL have parameter IMG_W, default 1920, active pixels per row.
REQ-003 SHALL have parameter IMG_H, default 1080, active rows per frame.
REQ-004 SHALL have parameters ROW_HEAD_NUM and ROW_TAIL_NUM, default 8 each, words discarded before/after each row.
REQ-005 SHALL have parameters PIC_HEAD_NUM and PIC_TAIL_NUM, default 7744 each, words discarded before/after each frame; all count parameters are at least 1.
REQ-006 SHALL have parameter START_SEC, default 16640, first sector of the clip.
REQ-007 SHALL have parameter BAYER_INIT, default 2'd1, channel code of pixel (row 0, col 0): 0=R, 1=Gr, 2=Gb, 3=B.
REQ-008 SHALL have the ports:
clk  in  1  single clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  level; start/continue clip playback
loop_en  in  1  restart clip after last sector
shift_mode  in  2  data right-shift: 0=none, 1=>>2, 2=>>4, 3=>>6
sd_sec_num  in  26  sectors per clip
rd_busy  in  1  SD read busy
sd_rd_val_en  in  1  SD word valid
sd_rd_val_data  in  DATA_W  SD word
rd_start_en  out  1  one-cycle sector read request
rd_sec_addr  out  32  sector address
ddr_wr_en  out  1  pixel write strobe
ddr_wr_data  out  DATA_W  pixel data
ddr_wr_chan  out  2  Bayer channel code of pixel
frame_done  out  1  one-cycle pulse, frame complete
frame_cnt  out  16  completed frames
busy  out  1  sequencer not in IDLE/DONE

Function
REQ-009 Sequencer states SHALL be IDLE, WAIT, DONE; falling edge of rd_busy detected from a two-flop delay (d1 & ~d0).
REQ-010 IDLE with enable=1 and sd_sec_num!=0 SHALL load rd_sec_addr=START_SEC, pulse rd_start_en, go WAIT; sd_sec_num==0 SHALL stay IDLE.
REQ-011 WAIT on falling edge, sector count != sd_sec_num-1: rd_sec_addr+1, pulse rd_start_en next cycle-edge, count+1.
REQ-012 WAIT on falling edge, last sector: count=0; loop_en=1 -> rd_sec_addr=START_SEC, pulse rd_start_en, stay WAIT; loop_en=0 -> DONE.
REQ-013 DONE SHALL return to IDLE when enable=0; enable=0 in WAIT SHALL finish current sector then go IDLE.
REQ-014 Parser states SHALL be PIC_HEAD, ROW_HEAD, ROW_DATA, ROW_TAIL, PIC_TAIL; each counts only cycles with sd_rd_val_en=1.
REQ-015 Transitions SHALL occur on the last counted word of each segment with no dead cycle; ROW_TAIL goes to ROW_HEAD, or PIC_TAIL after row IMG_H-1; PIC_TAIL goes to PIC_HEAD.
REQ-016 In ROW_DATA each valid word SHALL produce ddr_wr_en=1 exactly one cycle later, with ddr_wr_data = sd_rd_val_data >> (2*shift_mode), zero-filled MSBs.
REQ-017 ddr_wr_chan SHALL equal BAYER_INIT XOR {row[0], col[0]}; column phase SHALL reset to 0 at every row start.
REQ-018 On last PIC_TAIL word, frame_done SHALL pulse one cycle and frame_cnt SHALL increment, wrapping 16'hFFFF->0.
REQ-019 Sequencer restart at START_SEC (loop or from IDLE) SHALL force parser to PIC_HEAD with all counters cleared, same cycle as rd_start_en.
REQ-020 shift_mode SHALL be sampled per word; a change mid-row affects only subsequent words.

Reset
REQ-021 On rst_n=0, asynchronously: all outputs 0, rd_sec_addr=0, both FSMs in initial state (IDLE, PIC_HEAD), all counters and busy-edge flops 0.
REQ-022 Reset mid-frame SHALL discard partial frame; no ddr_wr_en or frame_done until a new full header is parsed.

Verification
REQ-023 IMG_W=4, IMG_H=2, ROW_HEAD/TAIL=2, PIC_HEAD/TAIL=3, BAYER_INIT=1, 22 words streamed -> exactly 8 ddr_wr_en, chan 1,0,1,0,3,2,3,2, one frame_done, frame_cnt=1.
REQ-024 sd_sec_num=3, loop_en=0, three rd_busy pulses -> rd_start_en at addr 16640,16641,16642, then DONE, busy=0.
REQ-025 sd_sec_num=2, loop_en=1, four busy pulses -> addresses 16640,16641,16640,16641; parser reset at each restart.
REQ-026 shift_mode=2, data 16'hABC0 -> ddr_wr_data 16'h0ABC, one cycle after valid.
REQ-027 frame_cnt preset to 16'hFFFF via 65535 frames (or forced) + one frame -> frame_cnt=0, frame_done pulses.
REQ-028 rst_n low mid-ROW_DATA, then release and stream -> outputs 0 during reset, first ddr_wr_en only after PIC_HEAD_NUM+ROW_HEAD_NUM words.
